// File: rtl/indirect_resid_gate.sv
// Indirect (feature-match) VO back-end: aligns the frame-0 matched index with
// the projected index coming back from the external projection pipeline,
// forms signed reprojection residuals, gates outliers against per-frame
// thresholds and accumulates per-frame inlier/total/L1 statistics.
// The L1 accumulator assumes SUM_BW is wider than one |dx|+|dy| term.
module indirect_resid_gate #(
    parameter int H_BW      = 10,
    parameter int V_BW      = 9,
    parameter int ALIGN_LAT = 11,
    parameter int CNT_BW    = 20,
    parameter int SUM_BW    = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_frame_start,
    input  logic                     i_frame_end,
    input  logic                     i_valid,
    input  logic [H_BW-1:0]          i_idx1_x,
    input  logic [V_BW-1:0]          i_idx1_y,
    input  logic                     i_proj_valid,
    input  logic [H_BW-1:0]          i_proj_x,
    input  logic [V_BW-1:0]          i_proj_y,
    input  logic [H_BW-1:0]          r_thresh_x,
    input  logic [V_BW-1:0]          r_thresh_y,
    input  logic                     r_gate_en,
    output logic                     o_frame_start,
    output logic                     o_frame_end,
    output logic                     o_valid,
    output logic                     o_inlier,
    output logic signed [H_BW:0]     o_diffs_x,
    output logic signed [V_BW:0]     o_diffs_y,
    output logic                     o_stat_valid,
    output logic [CNT_BW-1:0]        o_inlier_cnt,
    output logic [CNT_BW-1:0]        o_total_cnt,
    output logic [SUM_BW-1:0]        o_l1_sum,
    output logic                     o_align_err
);

    localparam int MAX_BW = (H_BW > V_BW) ? H_BW : V_BW;
    localparam int ABS_W  = MAX_BW + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;

    logic            dl_valid [ALIGN_LAT];
    logic            dl_start [ALIGN_LAT];
    logic            dl_end   [ALIGN_LAT];
    logic [H_BW-1:0] dl_x     [ALIGN_LAT];
    logic [V_BW-1:0] dl_y     [ALIGN_LAT];

    logic            d_valid;
    logic            d_frame_start;
    logic            d_frame_end;
    logic [H_BW-1:0] d_idx1_x;
    logic [V_BW-1:0] d_idx1_y;

    logic              samp_valid;
    logic signed [H_BW:0] dx;
    logic signed [V_BW:0] dy;
    logic [H_BW:0]     abs_dx;
    logic [V_BW:0]     abs_dy;
    logic [ABS_W-1:0]  abs_sum;
    logic [H_BW-1:0]   thr_x_eff;
    logic [V_BW-1:0]   thr_y_eff;
    logic              gate_eff;
    logic              inlier_now;
    logic              acc_en;

    logic [H_BW-1:0]   thr_x_s;
    logic [V_BW-1:0]   thr_y_s;
    logic              gate_en_s;

    logic [CNT_BW-1:0] total_acc;
    logic [CNT_BW-1:0] inlier_acc;
    logic [SUM_BW-1:0] l1_acc;
    logic [CNT_BW-1:0] base_total;
    logic [CNT_BW-1:0] base_inlier;
    logic [SUM_BW-1:0] base_l1;

    function automatic logic [CNT_BW-1:0] sat_inc(input logic [CNT_BW-1:0] a,
                                                  input logic inc);
        return (inc && (a != '1)) ? a + CNT_BW'(1) : a;
    endfunction

    function automatic logic [SUM_BW-1:0] sat_l1(input logic [SUM_BW-1:0] a,
                                                 input logic [ABS_W-1:0] b);
        logic [SUM_BW:0] w;
        w = {1'b0, a} + (SUM_BW+1)'(b);
        return w[SUM_BW] ? '1 : w[SUM_BW-1:0];
    endfunction

    assign d_valid       = dl_valid[ALIGN_LAT-1];
    assign d_frame_start = dl_start[ALIGN_LAT-1];
    assign d_frame_end   = dl_end[ALIGN_LAT-1];
    assign d_idx1_x      = dl_x[ALIGN_LAT-1];
    assign d_idx1_y      = dl_y[ALIGN_LAT-1];

    // Entry-side shift register so idx1 and markers meet the projection result
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < ALIGN_LAT; i++) begin
                dl_valid[i] <= 1'b0;
                dl_start[i] <= 1'b0;
                dl_end[i]   <= 1'b0;
                dl_x[i]     <= '0;
                dl_y[i]     <= '0;
            end
        end else begin
            dl_valid[0] <= i_valid;
            dl_start[0] <= i_frame_start;
            dl_end[0]   <= i_frame_end;
            dl_x[0]     <= i_idx1_x;
            dl_y[0]     <= i_idx1_y;
            for (int i = 1; i < ALIGN_LAT; i++) begin
                dl_valid[i] <= dl_valid[i-1];
                dl_start[i] <= dl_start[i-1];
                dl_end[i]   <= dl_end[i-1];
                dl_x[i]     <= dl_x[i-1];
                dl_y[i]     <= dl_y[i-1];
            end
        end
    end

    // Residuals, gate decision and accumulator bases; the start cycle sees the live thresholds
    always_comb begin
        samp_valid  = d_valid & i_proj_valid;
        dx          = $signed({1'b0, d_idx1_x}) - $signed({1'b0, i_proj_x});
        dy          = $signed({1'b0, d_idx1_y}) - $signed({1'b0, i_proj_y});
        abs_dx      = dx[H_BW] ? $unsigned(-dx) : $unsigned(dx);
        abs_dy      = dy[V_BW] ? $unsigned(-dy) : $unsigned(dy);
        abs_sum     = ABS_W'(abs_dx) + ABS_W'(abs_dy);
        thr_x_eff   = d_frame_start ? r_thresh_x : thr_x_s;
        thr_y_eff   = d_frame_start ? r_thresh_y : thr_y_s;
        gate_eff    = d_frame_start ? r_gate_en  : gate_en_s;
        inlier_now  = samp_valid & (~gate_eff |
                      ((abs_dx <= {1'b0, thr_x_eff}) & (abs_dy <= {1'b0, thr_y_eff})));
        acc_en      = d_frame_start | (state == ACC);
        base_total  = d_frame_start ? '0 : total_acc;
        base_inlier = d_frame_start ? '0 : inlier_acc;
        base_l1     = d_frame_start ? '0 : l1_acc;
    end

    // Registered residual stage; diffs hold their last valid value
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_valid       <= 1'b0;
            o_inlier      <= 1'b0;
            o_diffs_x     <= '0;
            o_diffs_y     <= '0;
            o_frame_start <= 1'b0;
            o_frame_end   <= 1'b0;
        end else begin
            o_valid       <= samp_valid;
            o_inlier      <= inlier_now;
            o_frame_start <= d_frame_start;
            o_frame_end   <= d_frame_end;
            if (samp_valid) begin
                o_diffs_x <= dx;
                o_diffs_y <= dy;
            end
        end
    end

    // Frame FSM: shadows, saturating accumulators, publish and sticky misalignment flag
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            thr_x_s      <= '0;
            thr_y_s      <= '0;
            gate_en_s    <= 1'b0;
            total_acc    <= '0;
            inlier_acc   <= '0;
            l1_acc       <= '0;
            o_stat_valid <= 1'b0;
            o_inlier_cnt <= '0;
            o_total_cnt  <= '0;
            o_l1_sum     <= '0;
            o_align_err  <= 1'b0;
        end else begin
            if ((d_valid != i_proj_valid) || (d_frame_start && (state == ACC))) begin
                o_align_err <= 1'b1;
            end

            if (acc_en) begin
                total_acc  <= sat_inc(base_total, samp_valid);
                inlier_acc <= sat_inc(base_inlier, inlier_now);
                l1_acc     <= sat_l1(base_l1, inlier_now ? abs_sum : '0);
            end

            o_stat_valid <= (state == DONE);
            if (state == DONE) begin
                o_total_cnt  <= total_acc;
                o_inlier_cnt <= inlier_acc;
                o_l1_sum     <= l1_acc;
            end

            if (d_frame_start) begin
                thr_x_s   <= r_thresh_x;
                thr_y_s   <= r_thresh_y;
                gate_en_s <= r_gate_en;
                state     <= d_frame_end ? DONE : ACC;
            end else begin
                case (state)
                    ACC:     state <= d_frame_end ? DONE : ACC;
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_indirect_resid_gate.sv
// Bench for indirect_resid_gate: directed frames plus randomized frames,
// checked each cycle against a frame-level reference model (queues of
// per-sample residuals summed at frame end). A second instance with a
// 3-bit counter width exercises count saturation.
module tb_indirect_resid_gate;

    localparam int H_BW = 10;
    localparam int V_BW = 9;
    localparam int LAT  = 11;
    localparam int XMAX = 1023;
    localparam int YMAX = 511;

    typedef struct packed {
        logic            vld;
        logic            st;
        logic            en;
        logic [H_BW-1:0] x1;
        logic [V_BW-1:0] y1;
        logic            pvld;
        logic [H_BW-1:0] px;
        logic [V_BW-1:0] py;
    } ent_t;

    logic            i_clk;
    logic            i_rst_n;
    logic            i_frame_start, i_frame_end, i_valid;
    logic [H_BW-1:0] i_idx1_x;
    logic [V_BW-1:0] i_idx1_y;
    logic            i_proj_valid;
    logic [H_BW-1:0] i_proj_x;
    logic [V_BW-1:0] i_proj_y;
    logic [H_BW-1:0] r_thresh_x;
    logic [V_BW-1:0] r_thresh_y;
    logic            r_gate_en;

    logic            o_frame_start, o_frame_end, o_valid, o_inlier;
    logic [H_BW:0]   o_diffs_x;
    logic [V_BW:0]   o_diffs_y;
    logic            o_stat_valid;
    logic [19:0]     o_inlier_cnt, o_total_cnt;
    logic [31:0]     o_l1_sum;
    logic            o_align_err;

    logic            s_frame_start, s_frame_end, s_valid, s_inlier;
    logic [H_BW:0]   s_diffs_x;
    logic [V_BW:0]   s_diffs_y;
    logic            s_stat_valid;
    logic [2:0]      s_inlier_cnt, s_total_cnt;
    logic [31:0]     s_l1_sum;
    logic            s_align_err;

    indirect_resid_gate #(.H_BW(H_BW), .V_BW(V_BW), .ALIGN_LAT(LAT), .CNT_BW(20), .SUM_BW(32)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_frame_start(i_frame_start), .i_frame_end(i_frame_end), .i_valid(i_valid),
        .i_idx1_x(i_idx1_x), .i_idx1_y(i_idx1_y),
        .i_proj_valid(i_proj_valid), .i_proj_x(i_proj_x), .i_proj_y(i_proj_y),
        .r_thresh_x(r_thresh_x), .r_thresh_y(r_thresh_y), .r_gate_en(r_gate_en),
        .o_frame_start(o_frame_start), .o_frame_end(o_frame_end),
        .o_valid(o_valid), .o_inlier(o_inlier),
        .o_diffs_x(o_diffs_x), .o_diffs_y(o_diffs_y),
        .o_stat_valid(o_stat_valid), .o_inlier_cnt(o_inlier_cnt),
        .o_total_cnt(o_total_cnt), .o_l1_sum(o_l1_sum), .o_align_err(o_align_err)
    );

    indirect_resid_gate #(.H_BW(H_BW), .V_BW(V_BW), .ALIGN_LAT(LAT), .CNT_BW(3), .SUM_BW(32)) dut_sat (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_frame_start(i_frame_start), .i_frame_end(i_frame_end), .i_valid(i_valid),
        .i_idx1_x(i_idx1_x), .i_idx1_y(i_idx1_y),
        .i_proj_valid(i_proj_valid), .i_proj_x(i_proj_x), .i_proj_y(i_proj_y),
        .r_thresh_x(r_thresh_x), .r_thresh_y(r_thresh_y), .r_gate_en(r_gate_en),
        .o_frame_start(s_frame_start), .o_frame_end(s_frame_end),
        .o_valid(s_valid), .o_inlier(s_inlier),
        .o_diffs_x(s_diffs_x), .o_diffs_y(s_diffs_y),
        .o_stat_valid(s_stat_valid), .o_inlier_cnt(s_inlier_cnt),
        .o_total_cnt(s_total_cnt), .o_l1_sum(s_l1_sum), .o_align_err(s_align_err)
    );

    int n_errors;
    int n_checks;

    // Projection pipeline stand-in: entries come back LAT cycles after issue
    ent_t pipe[$];

    // Reference model state
    logic          exp_valid, exp_inlier, exp_fs, exp_fe, exp_sv, exp_err;
    logic [H_BW:0] hold_dx;
    logic [V_BW:0] hold_dy;
    int            stat_tot, stat_inl, stat_l1;
    int            pend_tot, pend_inl, pend_l1;
    bit            pend, in_frame;
    bit            sh_gate;
    int            sh_tx, sh_ty;
    int            q_inl[$];
    int            q_abs[$];

    // Free-running clock
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int sat(input int v, input int bw);
        int mx;
        mx = (1 << bw) - 1;
        return (v > mx) ? mx : v;
    endfunction

    function automatic int rand_diff();
        return int'($urandom_range(40, 0)) - 20;
    endfunction

    function automatic ent_t mk_idle();
        ent_t e;
        e      = '0;
        e.x1   = H_BW'($urandom);
        e.y1   = V_BW'($urandom);
        e.px   = H_BW'($urandom);
        e.py   = V_BW'($urandom);
        return e;
    endfunction

    function automatic ent_t mk_sample(input logic st, input logic en, input int ddx, input int ddy);
        ent_t e;
        int x1;
        int y1;
        if (ddx >= 0) x1 = ddx + int'($urandom_range(32'(XMAX - ddx), 0));
        else          x1 = int'($urandom_range(32'(XMAX + ddx), 0));
        if (ddy >= 0) y1 = ddy + int'($urandom_range(32'(YMAX - ddy), 0));
        else          y1 = int'($urandom_range(32'(YMAX + ddy), 0));
        e.vld  = 1'b1;
        e.st   = st;
        e.en   = en;
        e.x1   = H_BW'(x1);
        e.y1   = V_BW'(y1);
        e.pvld = 1'b1;
        e.px   = H_BW'(x1 - ddx);
        e.py   = V_BW'(y1 - ddy);
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic checkAll();
        checkOutput("o_valid",       64'(o_valid),       64'(exp_valid));
        checkOutput("o_inlier",      64'(o_inlier),      64'(exp_inlier));
        checkOutput("o_diffs_x",     64'(o_diffs_x),     64'(hold_dx));
        checkOutput("o_diffs_y",     64'(o_diffs_y),     64'(hold_dy));
        checkOutput("o_frame_start", 64'(o_frame_start), 64'(exp_fs));
        checkOutput("o_frame_end",   64'(o_frame_end),   64'(exp_fe));
        checkOutput("o_stat_valid",  64'(o_stat_valid),  64'(exp_sv));
        checkOutput("o_total_cnt",   64'(o_total_cnt),   64'(sat(stat_tot, 20)));
        checkOutput("o_inlier_cnt",  64'(o_inlier_cnt),  64'(sat(stat_inl, 20)));
        checkOutput("o_l1_sum",      64'(o_l1_sum),      64'(stat_l1));
        checkOutput("o_align_err",   64'(o_align_err),   64'(exp_err));
        checkOutput("sat_stat_valid", 64'(s_stat_valid), 64'(exp_sv));
        checkOutput("sat_total_cnt",  64'(s_total_cnt),  64'(sat(stat_tot, 3)));
        checkOutput("sat_inlier_cnt", 64'(s_inlier_cnt), 64'(sat(stat_inl, 3)));
    endtask

    // One clock: issue entry e, return the projection issued LAT cycles ago, update model, check
    task automatic applyStimulus(input ent_t e);
        ent_t f;
        int   dx;
        int   dy;
        bit   v;
        bit   inl;
        pipe.push_back(e);
        f = pipe.pop_front();

        i_valid       = e.vld;
        i_frame_start = e.st;
        i_frame_end   = e.en;
        i_idx1_x      = e.x1;
        i_idx1_y      = e.y1;
        i_proj_valid  = f.pvld;
        i_proj_x      = f.px;
        i_proj_y      = f.py;

        if (pend) begin
            exp_sv   = 1'b1;
            stat_tot = pend_tot;
            stat_inl = pend_inl;
            stat_l1  = pend_l1;
            pend     = 0;
        end else begin
            exp_sv = 1'b0;
        end

        v  = f.vld && f.pvld;
        dx = int'(f.x1) - int'(f.px);
        dy = int'(f.y1) - int'(f.py);
        if (f.vld != f.pvld) exp_err = 1'b1;
        if (f.st) begin
            if (in_frame) exp_err = 1'b1;
            in_frame = 1;
            q_inl.delete();
            q_abs.delete();
            sh_gate = r_gate_en;
            sh_tx   = int'(r_thresh_x);
            sh_ty   = int'(r_thresh_y);
        end
        inl = v && (!sh_gate || (iabs(dx) <= sh_tx && iabs(dy) <= sh_ty));
        exp_valid  = v;
        exp_inlier = inl;
        exp_fs     = f.st;
        exp_fe     = f.en;
        if (v) begin
            hold_dx = (H_BW+1)'(dx);
            hold_dy = (V_BW+1)'(dy);
        end
        if (in_frame && v) begin
            q_inl.push_back(int'(inl));
            q_abs.push_back(iabs(dx) + iabs(dy));
        end
        if (in_frame && f.en) begin
            pend_tot = q_inl.size();
            pend_inl = 0;
            pend_l1  = 0;
            foreach (q_inl[k]) begin
                pend_inl += q_inl[k];
                if (q_inl[k] != 0) pend_l1 += q_abs[k];
            end
            pend     = 1;
            in_frame = 0;
        end

        @(posedge i_clk);
        #1;
        checkAll();
    endtask

    task automatic flush();
        repeat (LAT + 3) applyStimulus(mk_idle());
    endtask

    task automatic resetDut();
        i_rst_n       = 1'b0;
        i_valid       = 1'b0;
        i_frame_start = 1'b0;
        i_frame_end   = 1'b0;
        i_proj_valid  = 1'b0;
        repeat (2) begin
            @(posedge i_clk);
            #1;
        end
        pipe.delete();
        repeat (LAT) pipe.push_back('0);
        exp_valid = 0; exp_inlier = 0; exp_fs = 0; exp_fe = 0; exp_sv = 0; exp_err = 0;
        hold_dx = '0; hold_dy = '0;
        stat_tot = 0; stat_inl = 0; stat_l1 = 0;
        pend = 0; in_frame = 0; sh_gate = 0; sh_tx = 0; sh_ty = 0;
        q_inl.delete();
        q_abs.delete();
        checkAll();
        i_rst_n = 1'b1;
    endtask

    // Directed scenarios followed by randomized frames
    initial begin
        ent_t e;
        ent_t b;
        int   dxs[4];
        int   dys[4];
        int   n;
        n_errors = 0;
        n_checks = 0;
        i_idx1_x = '0; i_idx1_y = '0; i_proj_x = '0; i_proj_y = '0;
        r_thresh_x = '0; r_thresh_y = '0; r_gate_en = 1'b0;
        dxs = '{1, -2, 10, 0};
        dys = '{1, 3, 0, -8};

        resetDut();

        $display("[TB] single-sample frame (100,50) vs (97,55)");
        r_thresh_x = 10'd4; r_thresh_y = 9'd4; r_gate_en = 1'b1;
        e = mk_sample(1'b1, 1'b1, 0, 0);
        e.x1 = 10'd100; e.px = 10'd97; e.y1 = 9'd50; e.py = 9'd55;
        applyStimulus(e);
        flush();
        checkOutput("t1_diffs_x", 64'(o_diffs_x), 64'(11'd3));
        checkOutput("t1_diffs_y", 64'(o_diffs_y), 64'(10'h3FB));
        checkOutput("t1_total",   64'(o_total_cnt), 64'd1);
        checkOutput("t1_inlier",  64'(o_inlier_cnt), 64'd0);
        checkOutput("t1_l1",      64'(o_l1_sum), 64'd0);

        $display("[TB] four-sample frame, gate on and off");
        r_thresh_x = 10'd8; r_thresh_y = 9'd8; r_gate_en = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(mk_sample(i == 0, i == 3, dxs[i], dys[i]));
        flush();
        checkOutput("t2_total",  64'(o_total_cnt), 64'd4);
        checkOutput("t2_inlier", 64'(o_inlier_cnt), 64'd3);
        checkOutput("t2_l1",     64'(o_l1_sum), 64'd15);
        r_gate_en = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(mk_sample(i == 0, i == 3, dxs[i], dys[i]));
        flush();
        checkOutput("t3_inlier", 64'(o_inlier_cnt), 64'd4);
        checkOutput("t3_l1",     64'(o_l1_sum), 64'd25);

        $display("[TB] threshold change mid-frame");
        r_thresh_x = 10'd8; r_thresh_y = 9'd8; r_gate_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 15) begin
                r_thresh_x = 10'd2;
                r_thresh_y = 9'd2;
            end
            applyStimulus(mk_sample(i == 0, i == 19, 5, -5));
        end
        flush();
        checkOutput("t4_inlier_old_thr", 64'(o_inlier_cnt), 64'd20);
        for (int i = 0; i < 3; i++) applyStimulus(mk_sample(i == 0, i == 2, 5, -5));
        flush();
        checkOutput("t4_inlier_new_thr", 64'(o_inlier_cnt), 64'd0);

        $display("[TB] edge indices");
        r_gate_en = 1'b0;
        e = mk_sample(1'b1, 1'b1, 0, 0);
        e.x1 = 10'd0; e.px = 10'd1023; e.y1 = 9'd0; e.py = 9'd511;
        applyStimulus(e);
        flush();
        checkOutput("t5_diffs_x", 64'(o_diffs_x), 64'(11'h401));
        checkOutput("t5_diffs_y", 64'(o_diffs_y), 64'(10'h201));
        checkOutput("t5_total",   64'(o_total_cnt), 64'd1);
        checkOutput("t5_l1",      64'(o_l1_sum), 64'd1534);

        $display("[TB] count saturation");
        for (int i = 0; i < 9; i++) applyStimulus(mk_sample(i == 0, i == 8, 0, 0));
        flush();
        checkOutput("t6_total",     64'(o_total_cnt), 64'd9);
        checkOutput("t6_sat_total", 64'(s_total_cnt), 64'd7);

        $display("[TB] late projection");
        applyStimulus(mk_sample(1'b1, 1'b0, 1, 1));
        e = mk_sample(1'b0, 1'b0, 2, 2);
        e.pvld = 1'b0;
        b = mk_idle();
        b.pvld = 1'b1; b.px = e.px; b.py = e.py;
        applyStimulus(e);
        applyStimulus(b);
        applyStimulus(mk_sample(1'b0, 1'b1, 3, 3));
        flush();
        checkOutput("t7_align_err", 64'(o_align_err), 64'd1);
        checkOutput("t7_total",     64'(o_total_cnt), 64'd2);
        flush();
        checkOutput("t7_align_err_sticky", 64'(o_align_err), 64'd1);

        $display("[TB] restart inside a frame");
        applyStimulus(mk_sample(1'b1, 1'b0, 1, 1));
        applyStimulus(mk_sample(1'b0, 1'b0, 1, 1));
        applyStimulus(mk_sample(1'b0, 1'b0, 1, 1));
        applyStimulus(mk_sample(1'b1, 1'b0, 1, 1));
        applyStimulus(mk_sample(1'b0, 1'b0, 1, 1));
        applyStimulus(mk_sample(1'b0, 1'b1, 1, 1));
        flush();
        checkOutput("t8_total", 64'(o_total_cnt), 64'd3);

        $display("[TB] reset mid-frame");
        for (int i = 0; i < 15; i++) applyStimulus(mk_sample(i == 0, 1'b0, rand_diff(), rand_diff()));
        resetDut();
        checkOutput("t9_err_cleared", 64'(o_align_err), 64'd0);
        for (int i = 0; i < 5; i++) applyStimulus(mk_sample(i == 0, i == 4, rand_diff(), rand_diff()));
        flush();
        checkOutput("t9_total", 64'(o_total_cnt), 64'd5);

        $display("[TB] randomized frames");
        for (int f = 0; f < 10; f++) begin
            repeat ($urandom_range(3, 0)) applyStimulus(mk_idle());
            r_thresh_x = 10'($urandom_range(15, 0));
            r_thresh_y = 9'($urandom_range(15, 0));
            r_gate_en  = 1'($urandom_range(1, 0));
            n = int'($urandom_range(12, 1));
            for (int k = 0; k < n; k++) begin
                if (k > 0 && $urandom_range(3, 0) == 0) applyStimulus(mk_idle());
                if ($urandom_range(7, 0) == 0) r_thresh_x = 10'($urandom_range(15, 0));
                applyStimulus(mk_sample(k == 0, k == n - 1, rand_diff(), rand_diff()));
            end
        end
        flush();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/indirect_resid_gate.md
Name: indirect_resid_gate

Overview:
- Generalised back-end for the indirect (feature-match) VO path.
- Takes the frame-0 matched index (idx1) at pipeline entry and the projected index returned by an external cloud/transform/projection pipeline ALIGN_LAT cycles later.
- Computes signed reprojection residuals and gates outliers against per-frame thresholds.
- Accumulates per-frame inlier count, total count and L1 residual sum for the solver's convergence and robustness checks.

Parameters:
- H_BW, 10, horizontal index width.
- V_BW, 9, vertical index width.
- ALIGN_LAT, 11, cycles from i_valid to the matching i_proj_valid; legal range 1..31.
- CNT_BW, 20, width of the sample counters.
- SUM_BW, 32, width of the L1 residual accumulator.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset: synchronous, active-low
- i_frame_start  in  1  first-sample marker, entry side
- i_frame_end  in  1  last-sample marker, entry side
- i_valid  in  1  entry sample valid
- i_idx1_x  in  H_BW  matched x index (unsigned), qualified by i_valid
- i_idx1_y  in  V_BW  matched y index (unsigned)
- i_proj_valid  in  1  projection result valid
- i_proj_x  in  H_BW  projected x (unsigned)
- i_proj_y  in  V_BW  projected y (unsigned)
- r_thresh_x  in  H_BW  inlier bound on |dx|
- r_thresh_y  in  V_BW  inlier bound on |dy|
- r_gate_en  in  1  1 = apply gate; 0 = every valid sample is an inlier
- o_frame_start  out  1  i_frame_start delayed ALIGN_LAT+1
- o_frame_end  out  1  i_frame_end delayed ALIGN_LAT+1
- o_valid  out  1  aligned residual valid
- o_inlier  out  1  sample passed gate; 0 when o_valid=0
- o_diffs_x  out  H_BW+1  signed idx1_x - proj_x
- o_diffs_y  out  V_BW+1  signed idx1_y - proj_y
- o_stat_valid  out  1  one-cycle pulse, stats below are final
- o_inlier_cnt  out  CNT_BW  inliers in last frame
- o_total_cnt  out  CNT_BW  valid samples in last frame
- o_l1_sum  out  SUM_BW  sum of |dx|+|dy| over inliers
- o_align_err  out  1  sticky misalignment flag

Behaviour:
- Reset (i_rst_n=0 at a clock edge): all outputs, delay lines, counters, shadow thresholds and FSM state go to 0/IDLE. Reset mid-frame discards the frame; no o_stat_valid is produced for it.
- Alignment: i_valid, i_idx1_x/y, i_frame_start and i_frame_end pass through an ALIGN_LAT-stage shift register. Stage output (d_*) is used in the same cycle as i_proj_*.
- Residual stage (1 register):
  - dx = {0,d_idx1_x} - {0,i_proj_x}, H_BW+1 signed; dy likewise. No overflow is possible.
  - o_valid = d_valid & i_proj_valid. o_diffs_* update only when o_valid would be 1, otherwise they hold.
  - Total latency from entry to o_valid = ALIGN_LAT+1.
- Gate: inlier = !gate_en_s | (|dx| <= thr_x_s & |dy| <= thr_y_s), where *_s are shadows of r_gate_en and r_thresh_* latched when d_frame_start=1. Register changes mid-frame have no effect until the next frame.
- o_align_err: set when d_valid != i_proj_valid in any cycle. Cleared only by reset. Residual output still follows the AND rule.
- FSM on the delayed markers:
  - IDLE -> ACC on d_frame_start.
  - ACC -> DONE on d_frame_end.
  - DONE -> IDLE after one cycle. DONE drives o_stat_valid=1.
  - d_frame_start in ACC restarts accumulation; the partial frame is dropped and o_align_err is set.
  - d_frame_start and d_frame_end in the same cycle form a one-sample frame: clear, include the sample, publish.
- Accumulators:
  - Cleared on d_frame_start. A valid sample in the same cycle counts as the first sample.
  - Add only in ACC, or on the start cycle.
  - total += aligned valid; inlier_cnt += inlier; l1 += |dx|+|dy| for inliers only.
  - All saturate at all-ones; no wrap.
  - Sample coincident with d_frame_end is included.
  - Valid samples while IDLE produce residual outputs but are not accumulated.
- Stat outputs: loaded on entry to DONE. o_stat_valid asserts one cycle after o_frame_end. Stat values hold until the next publish.

Test Plan:
- Reset then one frame, ALIGN_LAT=11: idx1=(100,50), proj=(97,55), thr=(4,4), gate on -> o_valid at cycle 12, dx=+3, dy=-5, o_inlier=0; stats total=1, inlier=0, l1=0.
- 4-sample frame, thr=(8,8), diffs (1,1),(-2,3),(10,0),(0,-8) -> inlier=3, total=4, l1=15, o_stat_valid one cycle after o_frame_end.
- Same stimulus with r_gate_en=0 -> inlier=4, l1=25. Change r_thresh mid-frame -> no effect until the next frame.
- Edge values: idx1=0, proj=1023 -> dx=-1023. Single-sample frame (start=end=1) -> stats total=1. Saturation: CNT_BW=3 with 9 samples -> count=7.
- i_proj_valid one cycle late -> o_align_err=1 and stays 1. Back-to-back frame_start in ACC -> partial frame dropped.
- Sync reset asserted mid-frame, with no clock-free async behaviour -> outputs 0 at the next edge, no o_stat_valid. The next full frame produces correct stats.
